// File: rtl/weight_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// weight_fetch_sequencer
//
// Owns the single port of one neuron's weight BRAM. There are two jobs:
//   * While idle, host weight-load writes are forwarded into the BRAM, one per
//     cycle. Writes aimed past the last weight word are accepted but dropped.
//   * On start, every weight 0..DEPTH-1 is read in address order. Each word is
//     streamed to the MAC over a valid/ready handshake through a 2-entry FIFO.
//
// The BRAM samples its port on the falling edge. A read issued at rising edge
// E therefore has its data on bram_do at edge E+1.
//
// Ports
//   clk, rst_n            clock (rising edge) / asynchronous active-low reset
//   start                 begin a fetch pass (honoured in idle only)
//   busy, done            not idle / one-cycle pass-complete pulse
//   load_valid/ready      host write handshake; ready = idle & ~start
//   load_addr, load_data  host write address / data
//   bram_en/we/addr/di    registered BRAM port controls
//   bram_do               BRAM read data
//   w_data, w_index       head of the output FIFO and its weight address
//   w_valid, w_last       FIFO not empty / head is the last weight
//   w_ready               MAC accepts the head word this cycle
// -----------------------------------------------------------------------------
module weight_fetch_sequencer #(
    parameter int DEPTH  = 28,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_di,
    input  logic [DATA_W-1:0] bram_do,
    output logic [DATA_W-1:0] w_data,
    output logic [ADDR_W-1:0] w_index,
    output logic              w_valid,
    output logic              w_last,
    input  logic              w_ready
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   LAST_CNT  = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

    state_t            state_reg;
    // One bit wider than the address so it never wraps at DEPTH.
    logic [ADDR_W:0]   issue_cnt_reg;
    logic              inflight_reg;
    logic [1:0]        count_reg;
    logic              rd_ptr_reg;
    logic              wr_ptr_reg;

    logic              bram_en_reg;
    logic              bram_we_reg;
    logic [ADDR_W-1:0] bram_addr_reg;
    logic [DATA_W-1:0] bram_di_reg;

    logic [DATA_W-1:0] entry_data [2];
    logic [ADDR_W-1:0] entry_idx  [2];

    logic              push;
    logic              pop;
    logic [2:0]        occ_after_pop;
    logic              issue;
    logic [1:0]        count_next;
    logic              load_in_range;
    logic              fifo_clear;

    // Reads return exactly one edge after issue, so a pending read is always
    // consumed at the very next edge. Its index is still on bram_addr_reg then,
    // because the address register only changes when a new access is issued.
    assign push          = inflight_reg;
    assign pop           = w_valid & w_ready;
    assign occ_after_pop = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop};
    // Only issue if the word can be guaranteed a FIFO slot when it lands.
    assign issue         = (state_reg == ST_FETCH) && (occ_after_pop < 3'd2);
    assign count_next    = count_reg + {1'b0, push} - {1'b0, pop};
    assign load_in_range = ({1'b0, load_addr} < DEPTH_CNT);
    assign fifo_clear    = (state_reg == ST_IDLE) && start;

    assign load_ready = (state_reg == ST_IDLE) && !start;
    assign busy       = (state_reg != ST_IDLE);
    assign done       = (state_reg == ST_DONE);

    assign bram_en   = bram_en_reg;
    assign bram_we   = bram_we_reg;
    assign bram_addr = bram_addr_reg;
    assign bram_di   = bram_di_reg;

    // ---------------------------------------------------------------- FIFO
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            logic [DATA_W-1:0] data_reg;
            logic [ADDR_W-1:0] idx_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_reg <= '0;
                    idx_reg  <= '0;
                end else if (push && (wr_ptr_reg == 1'(gi))) begin
                    data_reg <= bram_do;
                    idx_reg  <= bram_addr_reg;
                end
            end

            assign entry_data[gi] = data_reg;
            assign entry_idx[gi]  = idx_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg  <= '0;
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
        end else if (fifo_clear) begin
            count_reg  <= '0;
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
        end else begin
            count_reg <= count_next;
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
        end
    end

    assign w_valid = (count_reg != 2'd0);
    assign w_data  = entry_data[rd_ptr_reg];
    assign w_index = entry_idx[rd_ptr_reg];
    assign w_last  = w_valid && (w_index == LAST_IDX);

    // ----------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            issue_cnt_reg <= '0;
            inflight_reg  <= 1'b0;
            bram_en_reg   <= 1'b0;
            bram_we_reg   <= 1'b0;
            bram_addr_reg <= '0;
            bram_di_reg   <= '0;
        end else begin
            // Strobes are single-cycle unless an access is issued below.
            bram_en_reg  <= 1'b0;
            bram_we_reg  <= 1'b0;
            inflight_reg <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        // The start edge doubles as the issue of address 0 so
                        // the first word is presented one cycle later.
                        bram_en_reg   <= 1'b1;
                        bram_addr_reg <= '0;
                        inflight_reg  <= 1'b1;
                        issue_cnt_reg <= (ADDR_W+1)'(1);
                        state_reg     <= (DEPTH == 1) ? ST_DRAIN : ST_FETCH;
                    end else if (load_valid && load_in_range) begin
                        bram_en_reg   <= 1'b1;
                        bram_we_reg   <= 1'b1;
                        bram_addr_reg <= load_addr;
                        bram_di_reg   <= load_data;
                    end
                end

                ST_FETCH: begin
                    if (issue) begin
                        bram_en_reg   <= 1'b1;
                        bram_addr_reg <= issue_cnt_reg[ADDR_W-1:0];
                        inflight_reg  <= 1'b1;
                        issue_cnt_reg <= issue_cnt_reg + 1'b1;
                        if (issue_cnt_reg == LAST_CNT) begin
                            state_reg <= ST_DRAIN;
                        end
                    end
                end

                ST_DRAIN: begin
                    // Leave as the last word is accepted, not one cycle later.
                    if (count_next == 2'd0) begin
                        state_reg <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/weight_fetch_sequencer.md
# weight_fetch_sequencer

Controller for one neuron's weight BRAM: 28 words × 16 bits, 5-bit address, synchronous read/write on the falling clock edge. It has two jobs:
- In idle, it arbitrates host weight-load writes into the BRAM.
- On START, it streams all DEPTH weights, in address order, to the neuron MAC over a valid/ready handshake.

It sits between the weight-load bus, the BRAM, and the MAC datapath. It is the only agent driving the BRAM port.

## Interface
Parameters:
- DEPTH, 28: number of weight words fetched per pass (addresses 0..DEPTH-1).
- ADDR_W, 5: BRAM address width.
- DATA_W, 16: weight word width.

Ports:
- CLK  in  1  clock. All controller logic is on the rising edge. The BRAM samples on the falling edge.
- RESET_N  in  1  reset; asynchronous, active-low.
- START  in  1  begin a fetch pass. Sampled in IDLE only.
- BUSY  out  1  high in any state other than IDLE.
- DONE  out  1  one-cycle pulse when a pass completes.
- LOAD_VALID  in  1  host write request.
- LOAD_READY  out  1  combinational: (state==IDLE) & ~START.
- LOAD_ADDR  in  ADDR_W  host write address.
- LOAD_DATA  in  DATA_W  host write data.
- BRAM_EN  out  1  BRAM enable. Registered.
- BRAM_WE  out  1  BRAM write enable. Registered.
- BRAM_ADDR  out  ADDR_W  BRAM address. Registered.
- BRAM_DI  out  DATA_W  BRAM write data. Registered.
- BRAM_DO  in  DATA_W  BRAM read data. Valid at the rising edge after a read is issued.
- W_DATA  out  DATA_W  weight to MAC. This is the head of the output FIFO.
- W_INDEX  out  ADDR_W  address of W_DATA.
- W_VALID  out  1  output FIFO not empty.
- W_LAST  out  1  W_INDEX == DEPTH-1, qualified by W_VALID.
- W_READY  in  1  MAC accepts. A transfer occurs when W_VALID & W_READY.

## Operation
- **States:** IDLE, FETCH, DRAIN, DONE.
- **IDLE, START=1:** go to FETCH. Clear the issue counter, FIFO and in-flight flag.
- **IDLE, START=0, LOAD_VALID=1:** register BRAM_EN=1, BRAM_WE=1, BRAM_ADDR=LOAD_ADDR, BRAM_DI=LOAD_DATA. The BRAM writes on the following falling edge.
  - Stay in IDLE. Back-to-back loads are accepted at one per cycle.
  - If LOAD_ADDR ≥ DEPTH, the write is accepted (handshake completes) but dropped: BRAM_EN stays 0.
- **START and LOAD_VALID together in IDLE:** START wins. LOAD_READY is 0 that cycle and the load stays pending.
- **FETCH:**
  - Issue a read whenever (fifo_count + inflight − pop) < 2, where pop = W_VALID & W_READY.
  - A read is BRAM_EN=1, BRAM_WE=0, BRAM_ADDR=issue_cnt. Then issue_cnt increments and inflight is set.
  - When an in-flight read's data returns, push BRAM_DO and its index into a 2-entry FIFO.
  - After the read of address DEPTH-1 is issued, go to DRAIN.
- **DRAIN:** issue no reads. When the FIFO is empty, nothing is in flight, and a pop is not pending, go to DONE.
- **DONE:** DONE=1 for exactly one cycle, then IDLE.
- **BRAM_EN:** 0 in every cycle with no issued access.
- **Ignored inputs:** START is ignored outside IDLE. LOAD_READY=0 outside IDLE.
- **Widths:** issue_cnt is ADDR_W+1 bits so it does not wrap at DEPTH. W_INDEX carries the low ADDR_W bits.
- **FIFO:** push and pop in the same cycle is legal; occupancy is unchanged. The FIFO never overflows because of the issue rule.

## Timing
- **Reset (RESET_N low, asynchronously):**
  - State = IDLE; FIFO, counters and inflight cleared.
  - BRAM_EN=0, BRAM_WE=0, BRAM_ADDR=0, BRAM_DI=0.
  - W_VALID=0, W_LAST=0, W_DATA=0, W_INDEX=0, BUSY=0, DONE=0.
  - LOAD_READY = ~START.
- **Reset mid-pass:** the pass is abandoned and the FIFO is flushed. BRAM contents are untouched. No DONE is produced.
- **Read latency:** a read issued at rising edge E returns data into the FIFO at E+1. W_VALID is high after E+1.
- **START sampled at E0:** address 0 is issued at E0, and W_VALID/W_INDEX=0 appears after E1.
- **With W_READY held at 1:**
  - Index k is presented after E(k+1), one word per cycle.
  - W_LAST is presented with index DEPTH-1, after E_DEPTH.
  - DONE is high between E_(DEPTH+1) and E_(DEPTH+2).
  - BUSY is high from E0 until E_(DEPTH+2).
- **Stall:** when W_READY=0, at most 2 words are buffered and issue stops. It resumes in the same cycle W_READY returns.

## Test plan
- **Load then fetch:**
  - Stimulus: write data 16'h0100+a to addresses 0..27 back-to-back, then START with W_READY=1.
  - Required response: 28 transfers with W_DATA=16'h0100..16'h011B and W_INDEX 0..27. W_LAST only on index 27. DONE pulses once, 30 cycles after START.
- **Backpressure:**
  - Stimulus: W_READY toggles 1,0,0,1 repeating during a pass.
  - Required response: all 28 words arrive in order, with no duplicates or drops. BRAM_EN never fires while FIFO plus in-flight equals 2.
- **Arbitration:**
  - Stimulus: LOAD_VALID and START high in the same IDLE cycle; then LOAD_VALID held during FETCH.
  - Required response: LOAD_READY=0 in both cases. BRAM_WE stays 0 until IDLE, then the load completes with 1 write.
- **Out-of-range load:**
  - Stimulus: LOAD_ADDR=28, 29 and 31.
  - Required response: LOAD_READY=1, BRAM_EN=0, and the next fetch returns unchanged data.
- **Reset mid-pass:**
  - Stimulus: RESET_N low at word 10 with W_READY=0.
  - Required response: all outputs go immediately to their reset values and no DONE is produced. A following START streams a full 28 words from index 0.
- **START while BUSY:**
  - Stimulus: a second START pulse during DRAIN.
  - Required response: it is ignored, giving exactly one DONE and 28 words.
